// File: rtl/fifo_synchronous_prog.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty, flush and sticky error flags.
// Define FWFT_EN for first-word-fall-through output; otherwise data_out is registered with one-edge latency.
module fifo_synchronous_prog #(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     flag_clr,
  input  logic                     store,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [POINTER_WIDTH:0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_afull,
  output logic                     fifo_aempty,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
);

  localparam int FIFO_DEPTH = 2 ** POINTER_WIDTH;
  localparam logic [POINTER_WIDTH:0] DEPTH_LVL  = (POINTER_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [POINTER_WIDTH:0] AFULL_LVL  = (POINTER_WIDTH+1)'(AFULL_THRESH);
  localparam logic [POINTER_WIDTH:0] AEMPTY_LVL = (POINTER_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [POINTER_WIDTH:0] PTR_ONE    = (POINTER_WIDTH+1)'(1);

  if (POINTER_WIDTH < 2) begin : g_pointer_width_error
    $error("fifo_synchronous_prog: POINTER_WIDTH must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_afull_error
    $error("fifo_synchronous_prog: AFULL_THRESH must lie in 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_aempty_error
    $error("fifo_synchronous_prog: AEMPTY_THRESH must lie in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [POINTER_WIDTH:0]   w_addr_q, w_addr_d;
  logic [POINTER_WIDTH:0]   r_addr_q, r_addr_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic [POINTER_WIDTH:0]   level;
  logic [POINTER_WIDTH-1:0] w_idx, r_idx;
  logic                     full, empty;
  logic                     read_en, write_en;

  assign level = w_addr_q - r_addr_q;
  assign full  = (level == DEPTH_LVL);
  assign empty = (level == '0);
  assign w_idx = w_addr_q[POINTER_WIDTH-1:0];
  assign r_idx = r_addr_q[POINTER_WIDTH-1:0];

  // A pop frees a slot in the same edge, so a push at full is still accepted alongside it.
  assign read_en  = load & ~empty & ~flush;
  assign write_en = store & (~full | (load & ~empty)) & ~flush;

  assign fifo_level     = level;
  assign fifo_full      = full;
  assign fifo_empty     = empty;
  assign fifo_afull     = (level >= AFULL_LVL);
  assign fifo_aempty    = (level <= AEMPTY_LVL);
  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;

  always_comb begin
    w_addr_d = w_addr_q;
    r_addr_d = r_addr_q;
    if (flush) begin
      r_addr_d = w_addr_q;
    end else begin
      if (write_en) w_addr_d = w_addr_q + PTR_ONE;
      if (read_en)  r_addr_d = r_addr_q + PTR_ONE;
    end
  end

  // Set beats clear; requests ignored by a flush are not counted as refused.
  always_comb begin
    overflow_d  = (overflow_q  & ~flag_clr) | (store & ~write_en & ~flush);
    underflow_d = (underflow_q & ~flag_clr) | (load  & ~read_en  & ~flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q    <= '0;
      r_addr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[w_idx] <= data_in;
  end

`ifdef FWFT_EN
  assign data_out = mem[r_idx];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (read_en) rdata_d = mem[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign data_out = rdata_q;
`endif

endmodule

// File: tb/tb_fifo_synchronous_prog.sv
// Randomised self-checking bench for fifo_synchronous_prog against a queue-based occupancy model.
// Honours FWFT_EN the same way as the design.
module tb_fifo_synchronous_prog;

  localparam int DW    = 8;
  localparam int PW    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, flag_clr, store, load;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [PW:0]   fifo_level;
  logic          fifo_full, fifo_empty, fifo_afull, fifo_aempty;
  logic          fifo_overflow, fifo_underflow;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] expDout;
  bit            expOv, expUn;

  fifo_synchronous_prog #(
    .DATA_WIDTH(DW), .POINTER_WIDTH(PW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .flag_clr(flag_clr),
    .store(store), .load(load), .data_in(data_in), .data_out(data_out),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    expDout = '0;
    expOv = 1'b0;
    expUn = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    int lvl;
    lvl = modelQ.size();
    checkOutput({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    checkOutput({tag, "_full"}, 32'(fifo_full), 32'(lvl == DEPTH));
    checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'(lvl == 0));
    checkOutput({tag, "_afull"}, 32'(fifo_afull), 32'(lvl >= AFT));
    checkOutput({tag, "_aempty"}, 32'(fifo_aempty), 32'(lvl <= AET));
    checkOutput({tag, "_overflow"}, 32'(fifo_overflow), 32'(expOv));
    checkOutput({tag, "_underflow"}, 32'(fifo_underflow), 32'(expUn));
`ifdef FWFT_EN
    if (lvl > 0) checkOutput({tag, "_dout"}, 32'(data_out), 32'(modelQ[0]));
`else
    checkOutput({tag, "_dout"}, 32'(data_out), 32'(expDout));
`endif
  endtask

  // One clock of stimulus; the model advances from the occupancy seen before the edge.
  task automatic applyStimulus(input string tag, input bit st, input bit ld, input bit fl,
                               input bit clr, input logic [DW-1:0] din);
    int  lvl;
    bit  rd, wr;
    store    = st;
    load     = ld;
    flush    = fl;
    flag_clr = clr;
    data_in  = din;
    @(posedge clk);
    lvl = modelQ.size();
    if (fl) begin
      modelQ.delete();
      expOv = expOv && !clr;
      expUn = expUn && !clr;
    end else begin
      rd = ld && (lvl > 0);
      wr = st && ((lvl < DEPTH) || rd);
      if (rd) expDout = modelQ.pop_front();
      if (wr) modelQ.push_back(din);
      expOv = (expOv && !clr) || (st && !wr);
      expUn = (expUn && !clr) || (ld && !rd);
    end
    #1;
    store = 1'b0; load = 1'b0; flush = 1'b0; flag_clr = 1'b0;
    checkAll(tag);
  endtask

  initial begin
    rst = 1'b1;
    store = 1'b0; load = 1'b0; flush = 1'b0; flag_clr = 1'b0; data_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    applyStimulus("ovf_store", 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    applyStimulus("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("full_pushpop", 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    for (int i = 0; i < 8; i++) applyStimulus("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
`ifndef FWFT_EN
    checkOutput("last_word_99", 32'(data_out), 32'h99);
`endif
    applyStimulus("unf_load", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("empty_pushpop", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    applyStimulus("unf_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("drain1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 40; i++)
      applyStimulus("wrap", 1'b1, (i > 0), 1'b0, 1'b0, DW'(8'h40 + i));
    applyStimulus("wrap_last", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) applyStimulus("lvl5", 1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h10 + i));
    applyStimulus("flush_store", 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    applyStimulus("after_flush_33", 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    applyStimulus("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Mid-operation asynchronous reset, observed before the next clock edge.
    for (int i = 0; i < 4; i++) applyStimulus("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
    applyStimulus("pre_rst_unf", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      int  stPct, ldPct;
      stPct = (i < 300) ? 70 : 35;
      ldPct = (i < 300) ? 35 : 70;
      applyStimulus("rand",
                    ($urandom_range(0, 99) < stPct),
                    ($urandom_range(0, 99) < ldPct),
                    ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 6),
                    DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
